// File: rtl/sum_checker_pkg.sv
// Shared types and default parameters for the sum_checker block.
package sum_checker_pkg;

    typedef enum logic {
        ST_ACQUIRE = 1'b0,
        ST_TRACK   = 1'b1
    } state_t;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_STEP  = 2;
    localparam int unsigned DEF_CNT_W = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;
    logic             w_at_max;

    assign w_at_max = &r_count;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && !w_at_max) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/sum_checker.sv
// Checks that valid adder sums advance by STEP with a consistent overflow flag.
// Define SUM_CHECKER_CAPTURE_EN to add first-mismatch capture outputs.
module sum_checker
    import sum_checker_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned STEP  = DEF_STEP,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_sum,
    input  logic             i_overflow,
    input  logic             i_clear,
    output logic             o_locked,
    output logic             o_error,
    output logic [CNT_W-1:0] o_chk_count,
    output logic [CNT_W-1:0] o_err_count
`ifdef SUM_CHECKER_CAPTURE_EN
    ,
    output logic [WIDTH-1:0] o_bad_sum,
    output logic [WIDTH-1:0] o_exp_sum,
    output logic             o_captured
`endif
);

    localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_ref_sum;
    logic             r_ref_ovf;
    logic             r_error;
    logic             r_locked;

    logic [WIDTH:0]   w_sum_ext;
    logic [WIDTH-1:0] w_exp_sum;
    logic             w_exp_ovf;
    logic             w_mismatch;
    logic             w_acq_valid;
    logic             w_trk_valid;
    logic             w_err_inc;

    // One extra bit so the carry out of ref + STEP becomes the wrap flag.
    assign w_sum_ext   = {1'b0, r_ref_sum} + STEP_EXT;
    assign w_exp_sum   = w_sum_ext[WIDTH-1:0];
    assign w_exp_ovf   = r_ref_ovf ^ w_sum_ext[WIDTH];
    assign w_mismatch  = (i_sum != w_exp_sum) || (i_overflow != w_exp_ovf);
    assign w_acq_valid = i_valid && !i_clear && (r_state == ST_ACQUIRE);
    assign w_trk_valid = i_valid && !i_clear && (r_state == ST_TRACK);
    assign w_err_inc   = w_trk_valid && w_mismatch;

    always_comb begin
        w_state_next = r_state;
        if (i_clear) begin
            w_state_next = ST_ACQUIRE;
        end else begin
            case (r_state)
                ST_ACQUIRE: if (i_valid) w_state_next = ST_TRACK;
                ST_TRACK:   w_state_next = ST_TRACK;
                default:    w_state_next = ST_ACQUIRE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state  <= ST_ACQUIRE;
            r_locked <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_locked <= (w_state_next == ST_TRACK);
            r_error  <= w_err_inc;
        end
    end

    // A mismatch resyncs to the received sample; a match advances to the expected one.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_ref_sum <= '0;
            r_ref_ovf <= 1'b0;
        end else if (w_acq_valid || w_err_inc) begin
            r_ref_sum <= i_sum;
            r_ref_ovf <= i_overflow;
        end else if (w_trk_valid) begin
            r_ref_sum <= w_exp_sum;
            r_ref_ovf <= w_exp_ovf;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_chk_counter (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (i_clear),
        .i_inc   (w_trk_valid),
        .o_count (o_chk_count)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_err_counter (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (i_clear),
        .i_inc   (w_err_inc),
        .o_count (o_err_count)
    );

    assign o_locked = r_locked;
    assign o_error  = r_error;

`ifdef SUM_CHECKER_CAPTURE_EN
    logic [WIDTH-1:0] r_bad_sum;
    logic [WIDTH-1:0] r_exp_sum;
    logic             r_captured;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_bad_sum  <= '0;
            r_exp_sum  <= '0;
            r_captured <= 1'b0;
        end else if (i_clear) begin
            r_bad_sum  <= '0;
            r_exp_sum  <= '0;
            r_captured <= 1'b0;
        end else if (w_err_inc && !r_captured) begin
            r_bad_sum  <= i_sum;
            r_exp_sum  <= w_exp_sum;
            r_captured <= 1'b1;
        end
    end

    assign o_bad_sum  = r_bad_sum;
    assign o_exp_sum  = r_exp_sum;
    assign o_captured = r_captured;
`endif

endmodule

// File: tb/tb_sum_checker.sv
// Randomised and directed bench for sum_checker against a behavioural sequence model.
module tb_sum_checker;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned STEP  = 2;
    localparam int unsigned CNT_W = 4;
    localparam int MOD  = 1 << WIDTH;
    localparam int CMAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             valid = 1'b0;
    logic [WIDTH-1:0] sum = '0;
    logic             ovf = 1'b0;
    logic             clear = 1'b0;
    logic             locked;
    logic             error;
    logic [CNT_W-1:0] chk_count;
    logic [CNT_W-1:0] err_count;

    int vectors = 0;
    int miscompares = 0;

    // Model: the last accepted sample is the reference for the next one.
    bit m_track = 0;
    int m_ref = 0;
    bit m_ovf = 0;
    int m_chk = 0;
    int m_err = 0;
    bit m_pulse = 0;

    always #5 clk = ~clk;

    sum_checker #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .CNT_W (CNT_W)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst_n),
        .i_valid     (valid),
        .i_sum       (sum),
        .i_overflow  (ovf),
        .i_clear     (clear),
        .o_locked    (locked),
        .o_error     (error),
        .o_chk_count (chk_count),
        .o_err_count (err_count)
    );

    function automatic void model_reset();
        m_track = 0; m_ref = 0; m_ovf = 0; m_chk = 0; m_err = 0; m_pulse = 0;
    endfunction

    // Applies one cycle of stimulus, advances the model, and returns #1 after the edge.
    task automatic drive(input bit v, input int s, input bit o, input bit c);
        int  nxt;
        bit  eo;
        valid = v; sum = WIDTH'(s); ovf = o; clear = c;
        m_pulse = 0;
        if (c) begin
            m_track = 0; m_chk = 0; m_err = 0;
        end else if (v) begin
            if (m_track) begin
                nxt = m_ref + STEP;
                eo  = m_ovf ^ (nxt >= MOD);
                m_chk = (m_chk < CMAX) ? m_chk + 1 : CMAX;
                if ((s != nxt % MOD) || (o != eo)) begin
                    m_err = (m_err < CMAX) ? m_err + 1 : CMAX;
                    m_pulse = 1;
                end
            end
            m_track = 1;
            m_ref = s;
            m_ovf = o;
        end
        @(posedge clk);
        #1;
        valid = 0; clear = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        #12;
        vectors++;
        if (locked !== 1'b0 || error !== 1'b0 || chk_count !== '0 || err_count !== '0) begin
            miscompares++;
            $display("FAIL reset: got lock=%0b err=%0b chk=%0d errs=%0d, want all 0",
                     locked, error, chk_count, err_count);
        end
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    task automatic test_seq(input string name, input int sums[4], input bit ovfs[4]);
        drive(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            drive(1, sums[i], ovfs[i], 0);
            vectors++;
            if (locked !== m_track || error !== m_pulse || chk_count !== m_chk ||
                err_count !== m_err) begin
                miscompares++;
                $display("FAIL %s[%0d]: got lock=%0b err=%0b chk=%0d errs=%0d, want %0b %0b %0d %0d",
                         name, i, locked, error, chk_count, err_count,
                         m_track, m_pulse, m_chk, m_err);
            end
        end
        drive(0, 0, 0, 0);
        vectors++;
        if (error !== 1'b0 || err_count !== m_err) begin
            miscompares++;
            $display("FAIL %s_tail: got err=%0b errs=%0d, want 0 %0d", name, error, err_count, m_err);
        end
    endtask

    task automatic test_saturate();
        drive(0, 0, 0, 1);
        drive(1, 0, 0, 0);
        for (int i = 0; i < 20; i++) drive(1, 0, 0, 0);
        vectors++;
        if (err_count !== 4'd15 || chk_count !== 4'd15 || error !== 1'b1 || locked !== 1'b1) begin
            miscompares++;
            $display("FAIL saturate: got errs=%0d chk=%0d err=%0b lock=%0b, want 15 15 1 1",
                     err_count, chk_count, error, locked);
        end
        drive(1, 2, 0, 1);
        vectors++;
        if (err_count !== '0 || chk_count !== '0 || locked !== 1'b0 || error !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_prio: got errs=%0d chk=%0d lock=%0b err=%0b, want 0 0 0 0",
                     err_count, chk_count, locked, error);
        end
    endtask

    task automatic test_random();
        int s;
        bit o, v, c;
        for (int i = 0; i < 300; i++) begin
            v = ($urandom % 4) != 0;
            c = ($urandom % 30) == 0;
            if (m_track && ($urandom % 5) != 0) begin
                s = (m_ref + STEP) % MOD;
                o = m_ovf ^ ((m_ref + STEP) >= MOD);
            end else begin
                s = int'($urandom % MOD);
                o = bit'($urandom % 2);
            end
            drive(v, s, o, c);
            vectors++;
            if (locked !== m_track || error !== m_pulse || chk_count !== m_chk ||
                err_count !== m_err) begin
                miscompares++;
                $display("FAIL random[%0d]: got lock=%0b err=%0b chk=%0d errs=%0d, want %0b %0b %0d %0d",
                         i, locked, error, chk_count, err_count, m_track, m_pulse, m_chk, m_err);
            end
        end
    endtask

    task automatic test_async_reset();
        drive(0, 0, 0, 1);
        drive(1, 5, 0, 0);
        drive(1, 8, 0, 0);
        drive(1, 3, 1, 0);
        #3;
        rst_n = 0;
        #1;
        vectors++;
        if (locked !== 1'b0 || error !== 1'b0 || chk_count !== '0 || err_count !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got lock=%0b err=%0b chk=%0d errs=%0d, want all 0",
                     locked, error, chk_count, err_count);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
        drive(1, 7, 0, 0);
        vectors++;
        if (locked !== 1'b1 || chk_count !== '0 || error !== 1'b0) begin
            miscompares++;
            $display("FAIL reacquire: got lock=%0b chk=%0d err=%0b, want 1 0 0",
                     locked, chk_count, error);
        end
        drive(1, 9, 0, 0);
        vectors++;
        if (chk_count !== 4'd1 || err_count !== '0 || error !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reacquire: got chk=%0d errs=%0d err=%0b, want 1 0 0",
                     chk_count, err_count, error);
        end
    endtask

    initial begin
        test_reset();
        test_seq("ramp",     '{0, 2, 4, 6},    '{0, 0, 0, 0});
        test_seq("wrap",     '{12, 14, 0, 2},  '{0, 0, 1, 1});
        test_seq("resync",   '{2, 4, 9, 11},   '{0, 0, 0, 0});
        test_seq("ovf_miss", '{4, 6, 8, 10},   '{0, 1, 1, 1});
        test_saturate();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sum_checker.md
SUM_CHECKER -- requirements
Module: sum_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 32, sum/result width in bits.
REQ-002 SHALL have parameter STEP, default 2, expected increment between consecutive valid sums.
REQ-003 SHALL have parameter CNT_W, default 16, width of the check and error counters.
REQ-004 SHALL have port i_clk, input, 1, sole clock; all logic rising-edge.
REQ-005 SHALL have port i_rst, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port i_valid, input, 1, qualifies i_sum/i_overflow this cycle.
REQ-007 SHALL have port i_sum, input, WIDTH, result sample from the adder output.
REQ-008 SHALL have port i_overflow, input, 1, overflow flag sampled with i_sum.
REQ-009 SHALL have port i_clear, input, 1, synchronous return to ACQUIRE with counters zeroed.
REQ-010 SHALL have port o_locked, output, 1, high while in TRACK.
REQ-011 SHALL have port o_error, output, 1, one-cycle pulse per mismatching sample.
REQ-012 SHALL have port o_chk_count, output, CNT_W, samples compared.
REQ-013 SHALL have port o_err_count, output, CNT_W, mismatches detected.

Function
REQ-014 SHALL implement FSM states ACQUIRE and TRACK; reset state ACQUIRE.
REQ-015 In ACQUIRE, on i_valid: capture i_sum, i_overflow as reference, no compare, go to TRACK next cycle.
REQ-016 In TRACK, exp_sum = (ref_sum + STEP) mod 2^WIDTH; wrap = 1 when ref_sum + STEP >= 2^WIDTH (computed at WIDTH+1 bits).
REQ-017 In TRACK, exp_ovf = ref_ovf XOR wrap.
REQ-018 In TRACK, on i_valid: mismatch = (i_sum != exp_sum) OR (i_overflow != exp_ovf); o_chk_count increments.
REQ-019 On mismatch: o_error high the following cycle for exactly one cycle; o_err_count increments; reference resyncs to the received i_sum/i_overflow; FSM stays in TRACK.
REQ-020 On match: reference becomes exp_sum/exp_ovf.
REQ-021 Cycles with i_valid low SHALL change no state, counter or reference.
REQ-022 Counters SHALL saturate at 2^CNT_W-1, never wrap.
REQ-023 i_clear SHALL take priority over i_valid in the same cycle: sample discarded, FSM to ACQUIRE, counters zero, o_error low next cycle.
REQ-024 o_locked SHALL be registered and equal (state == TRACK).

Reset
REQ-025 Reset assertion SHALL immediately force: state ACQUIRE, o_locked 0, o_error 0, o_chk_count 0, o_err_count 0, reference sum 0, reference overflow 0.
REQ-026 Reset asserted mid-TRACK SHALL discard the reference; the first valid sample after release re-acquires.

Configuration
REQ-027 Macro SUM_CHECKER_CAPTURE_EN defined: adds outputs o_bad_sum (WIDTH) and o_exp_sum (WIDTH) holding received/expected sums of the first mismatch since reset or i_clear, plus o_captured (1), high once captured; all reset to 0.
REQ-028 Macro undefined: those ports and registers do not exist; all other behaviour identical.

Structure
REQ-029 Shared package sum_checker_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-030 Sub-module sat_counter (CNT_W-bit saturating increment with clear) SHALL be instantiated twice; no other hierarchy.

Verification (WIDTH=4, STEP=2, CNT_W=4)
REQ-031 Reset, valid sums 0,2,4,6 ovf 0 -> o_locked 1 after first sample, o_chk_count 3, o_err_count 0.
REQ-032 Sums 12,14,0,2 with ovf 0,0,1,1 -> no error (wrap toggles overflow).
REQ-033 Sums 2,4,9,11 ovf 0 -> single o_error pulse at 9, o_err_count 1, 11 accepted after resync.
REQ-034 Sums 4,6 with ovf 0,1 -> overflow mismatch, o_err_count 1.
REQ-035 20 consecutive mismatches -> o_err_count saturates at 15; i_clear with i_valid high -> counters 0, o_locked 0.
REQ-036 Reset asserted mid-stream asynchronously -> outputs zero before next clock edge; first post-reset sample only acquires.
